uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART Rx path. It watches the serial line and uses the 16x oversampling tick from the baud generator to find a start bit and sample every bit at mid-bit. It assembles the 11-bit frame and hands it to the deframer as `data_parll` together with a one-cycle `recieved_flag`. It owns all Rx timing, so the deframer and error checker stay purely frame-level.

---
 rtl/uart_rx_ctrl.sv | 87 ++++++++
 tb/tb_uart_rx_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receive sequencer that finds the start bit, samples each bit at mid-bit
// and delivers the assembled frame with a one-cycle received pulse.
module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int FRAME_BITS = 11
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  baud_tick,
    input  logic                  rx_serial,
    output logic [FRAME_BITS-1:0] data_parll,
    output logic                  recieved_flag,
    output logic                  rx_busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [3:0] STOP_IDX = 4'(FRAME_BITS - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;
    state_t state, state_nx;
    logic rx_meta, rx_s;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0] idx, idx_nx;
    logic [FRAME_BITS-1:0] shreg, shreg_nx;
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        idx_nx = idx;
        shreg_nx = shreg;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                state_nx = rx_s ? IDLE : START;
            end
            START: if (baud_tick) begin
                if (cnt == HALF) begin
                    // mid-start sample: a high line here means the fall was a glitch
                    cnt_nx = '0;
                    if (rx_s) begin
                        state_nx = IDLE;
                    end else begin
                        shreg_nx[0] = 1'b0;
                        idx_nx = 4'd1;
                        state_nx = DATA;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DATA: if (baud_tick) begin
                if (cnt == LAST) begin
                    cnt_nx = '0;
                    shreg_nx[idx] = rx_s;
                    idx_nx = idx + 4'd1;
                    state_nx = (idx == STOP_IDX) ? DONE : DATA;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s <= 1'b1;
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            shreg <= '0;
            data_parll <= '1;
            recieved_flag <= 1'b0;
        end else begin
            rx_meta <= rx_serial;
            rx_s <= rx_meta;
            state <= state_nx;
            cnt <= cnt_nx;
            idx <= idx_nx;
            shreg <= shreg_nx;
            data_parll <= (state == DONE) ? shreg : data_parll;
            recieved_flag <= (state == DONE);
        end
    end
    // stays high through DONE so it drops on the same edge the flag rises
    assign rx_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and randomized frames against a serial-bit-order frame model.
module tb_uart_rx_ctrl;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic baud_tick = 1'b0;
    logic rx_serial = 1'b1;
    logic [10:0] data_parll;
    logic recieved_flag, rx_busy;
    int checks = 0;
    int passes = 0;
    int flag_cnt = 0;
    int double_pulse = 0;
    int busy_cycles = 0;
    int tphase = 0;
    logic prev_flag = 1'b0;
    logic [10:0] obs[$];

    uart_rx_ctrl dut (
        .clock(clock),
        .reset_n(reset_n),
        .baud_tick(baud_tick),
        .rx_serial(rx_serial),
        .data_parll(data_parll),
        .recieved_flag(recieved_flag),
        .rx_busy(rx_busy)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(negedge clock);
        baud_tick = (tphase == 0);
        tphase = (tphase + 1) % 4;
    end

    always @(negedge clock) begin
        if (recieved_flag) begin
            obs.push_back(data_parll);
            flag_cnt++;
            if (prev_flag) double_pulse++;
        end
        prev_flag = recieved_flag;
        if (rx_busy) busy_cycles++;
    end

    // frame as seen on the wire: bit i is the i-th serial bit
    function automatic logic [10:0] frame_of(logic [7:0] d, logic p, logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic idle(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bits(logic [10:0] f, int n);
        for (int i = 0; i < n; i++) begin
            rx_serial = f[i];
            idle(64);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle(5);
        checks++; if (data_parll !== 11'h7FF) $display("FAIL reset_data: got %h want 7ff", data_parll); else passes++;
        checks++; if (recieved_flag !== 1'b0) $display("FAIL reset_flag: got %b want 0", recieved_flag); else passes++;
        checks++; if (rx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", rx_busy); else passes++;
        reset_n = 1'b1;
        idle(20);
    endtask

    task automatic test_glitch;
        busy_cycles = 0;
        flag_cnt = 0;
        rx_serial = 1'b0;
        idle(16);
        rx_serial = 1'b1;
        idle(100);
        checks++; if (busy_cycles < 26 || busy_cycles > 40) $display("FAIL glitch_busy_len: got %0d want 26..40", busy_cycles); else passes++;
        checks++; if (flag_cnt !== 0) $display("FAIL glitch_flags: got %0d want 0", flag_cnt); else passes++;
        checks++; if (data_parll !== 11'h7FF) $display("FAIL glitch_data: got %h want 7ff", data_parll); else passes++;
    endtask

    task automatic test_single;
        obs.delete();
        busy_cycles = 0;
        send_bits(11'h54A, 11);
        idle(40);
        checks++; if (obs.size() !== 1) $display("FAIL single_flags: got %0d want 1", obs.size()); else passes++;
        checks++; if ((obs.size() > 0 ? obs[0] : 11'bx) !== 11'h54A) $display("FAIL single_data: got %h want 54a", data_parll); else passes++;
        checks++; if (busy_cycles < 660 || busy_cycles > 690) $display("FAIL single_busy_len: got %0d want 660..690", busy_cycles); else passes++;
        checks++; if (rx_busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", rx_busy); else passes++;
    endtask

    task automatic test_back_to_back;
        obs.delete();
        send_bits(11'h400, 11);
        send_bits(11'h5FE, 11);
        idle(40);
        checks++; if (obs.size() !== 2) $display("FAIL b2b_flags: got %0d want 2", obs.size()); else passes++;
        checks++; if ((obs.size() > 0 ? obs[0] : 11'bx) !== 11'h400) $display("FAIL b2b_first: got %h want 400", obs.size() > 0 ? obs[0] : 11'bx); else passes++;
        checks++; if ((obs.size() > 1 ? obs[1] : 11'bx) !== 11'h5FE) $display("FAIL b2b_second: got %h want 5fe", obs.size() > 1 ? obs[1] : 11'bx); else passes++;
    endtask

    task automatic test_framing_error;
        obs.delete();
        send_bits(11'h278, 11);
        checks++; if (obs.size() !== 1) $display("FAIL frerr_flags: got %0d want 1", obs.size()); else passes++;
        checks++; if (data_parll !== 11'h278) $display("FAIL frerr_data: got %h want 278", data_parll); else passes++;
    endtask

    task automatic test_held_low;
        obs.delete();
        idle(656);
        rx_serial = 1'b1;
        idle(150);
        checks++; if (obs.size() !== 1) $display("FAIL held_low_flags: got %0d want 1", obs.size()); else passes++;
        checks++; if (data_parll !== 11'h000) $display("FAIL held_low_data: got %h want 000", data_parll); else passes++;
        checks++; if (rx_busy !== 1'b0) $display("FAIL held_low_busy: got %b want 0", rx_busy); else passes++;
    endtask

    task automatic test_reset_mid;
        obs.delete();
        send_bits(11'h478, 5);
        checks++; if (rx_busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", rx_busy); else passes++;
        reset_n = 1'b0;
        rx_serial = 1'b1;
        #1;
        checks++; if (rx_busy !== 1'b0) $display("FAIL mid_busy_reset: got %b want 0", rx_busy); else passes++;
        checks++; if (data_parll !== 11'h7FF) $display("FAIL mid_data_reset: got %h want 7ff", data_parll); else passes++;
        checks++; if (recieved_flag !== 1'b0) $display("FAIL mid_flag_reset: got %b want 0", recieved_flag); else passes++;
        idle(3);
        reset_n = 1'b1;
        idle(20);
        send_bits(11'h478, 11);
        idle(40);
        checks++; if (obs.size() !== 1) $display("FAIL mid_flags: got %0d want 1", obs.size()); else passes++;
        checks++; if (data_parll !== 11'h478) $display("FAIL mid_data: got %h want 478", data_parll); else passes++;
    endtask

    task automatic test_random;
        logic [10:0] exp_q[$];
        logic [10:0] f;
        obs.delete();
        for (int n = 0; n < 10; n++) begin
            f = frame_of(8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            exp_q.push_back(f);
            send_bits(f, 11);
            idle($urandom_range(0, 80));
        end
        idle(40);
        checks++; if (obs.size() !== exp_q.size()) $display("FAIL rand_count: got %0d want %0d", obs.size(), exp_q.size()); else passes++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if ((i < obs.size() ? obs[i] : 11'bx) !== exp_q[i]) $display("FAIL rand_frame%0d: got %h want %h", i, i < obs.size() ? obs[i] : 11'bx, exp_q[i]); else passes++;
        end
        checks++; if (double_pulse !== 0) $display("FAIL flag_width: got %0d multi-cycle pulses want 0", double_pulse); else passes++;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single();
        test_back_to_back();
        test_framing_error();
        test_held_low();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
